if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk_in  input  1  single clock; all state updates on rising edge.
REQ-002 rst_in  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-003 stall_in  input  6  pipeline stall vector from stall controller; bit0 = PC hold, bit1 = IF hold.
REQ-004 branch_in  input  1  redirect request from EX; one-cycle pulse.
REQ-005 branchTarget_in  input  32  redirect PC, sampled when branch_in=1.
REQ-006 memGrant_in  input  1  byte port granted to IF this cycle.
REQ-007 memData_in  input  8  read byte, valid the cycle after a granted request.
REQ-008 memReq_out  output  1  IF requests byte port.
REQ-009 memAddr_out  output  32  byte address of request.
REQ-010 pc_out  output  32  PC of handed-off instruction.
REQ-011 inst_out  output  32  handed-off instruction, little-endian assembled.
REQ-012 instValid_out  output  1  one-cycle pulse: pc_out/inst_out valid for IF/ID.
REQ-013 ifStall_out  output  1  fetch incomplete; feeds stall controller.

Function
REQ-014 States: FETCH, HOLD; reset state FETCH with fetchPc = 0.
REQ-015 FETCH: issueCnt (0..4) and recvCnt (0..4) counters; memReq_out = 1 while issueCnt < 4, memAddr_out = fetchPc + issueCnt (mod 2^32).
REQ-016 issueCnt increments only in cycles with memReq_out=1 and memGrant_in=1.
REQ-017 A granted request returns memData_in next cycle; byte k written to inst bits [8k+7:8k]; recvCnt increments.
REQ-018 Grant deassertion pauses issuing without losing returned bytes; no request reissued.
REQ-019 ifStall_out = 1 in FETCH while recvCnt < 4; 0 in HOLD and in the completion cycle.
REQ-020 Completion (recvCnt reaches 4) with stall_in[1]=0: instValid_out=1 next cycle, pc_out=fetchPc, fetchPc += 4, counters cleared, remain FETCH.
REQ-021 Completion with stall_in[1]=1: enter HOLD, buffer instruction, memReq_out=0.
REQ-022 HOLD: on first cycle with stall_in[1]=0, instValid_out=1, fetchPc += 4, return to FETCH.
REQ-023 stall_in[0]=1 blocks fetchPc update; advance deferred until bit clears.
REQ-024 branch_in=1 overrides stall_in and any state: fetchPc = branchTarget_in, counters cleared, HOLD buffer discarded, state FETCH, instValid_out=0 that cycle.
REQ-025 Byte returning the cycle after a branch (from a pre-branch grant) is discarded, not counted.
REQ-026 branchTarget_in used unaligned as given; no alignment check.
REQ-027 instValid_out never asserted two consecutive cycles for the same instruction.

Reset
REQ-028 On rst_in=0, immediately: state FETCH, fetchPc=0, counters 0, drop flag 0, memReq_out=0, memAddr_out=0, pc_out=0, inst_out=0, instValid_out=0, ifStall_out=0.
REQ-029 Reset mid-fetch abandons partial instruction; first request one cycle after rst_in rises, address 0.

Structure
REQ-030 Shared package holds stall vector width (6), stall bit indices, state enum, instruction/address widths.
REQ-031 One sub-module, inst_assembler: byte counter and 32-bit little-endian assembly register with clear and drop inputs.

Verification
REQ-032 Reset release, memGrant_in=1 always, bytes 13,00,00,00 -> addresses 0..3 on consecutive cycles, instValid_out with inst_out=0x00000013, pc_out=0; next request address 4.
REQ-033 Grant low for 2 cycles after byte 1 -> no address repeated, inst assembled correctly, ifStall_out high 2 extra cycles.
REQ-034 Completion with stall_in=6'b011111 for 3 cycles -> HOLD, no memReq_out, instValid_out pulses on cycle stall clears, pc_out unchanged.
REQ-035 branch_in with target 0x100 after 2 bytes issued -> in-flight byte dropped, next address 0x100, instValid_out carries pc_out=0x100.
REQ-036 branch_in while in HOLD -> buffered instruction never emitted; fetch resumes at target.
REQ-037 rst_in pulled low mid-fetch (recvCnt=2) -> all outputs 0 same cycle; after release, fetch restarts at address 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch stage.
package if_fetch_pkg;

    // Stall vector from the stall controller and the bits this stage honours
    localparam int unsigned STALL_W  = 6;
    localparam int unsigned STALL_PC = 0;
    localparam int unsigned STALL_IF = 1;

    // Datapath widths
    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BYTE_W = 8;

    // Byte counters run 0..4, so they need three bits
    localparam int unsigned        CNT_W    = 3;
    localparam logic [CNT_W-1:0]   CNT_FULL = 3'd4;

    // Distance between consecutive instructions
    localparam logic [ADDR_W-1:0]  INST_BYTES = 32'd4;

    typedef enum logic {
        StFetch,
        StHold
    } fetch_state_t;

    // Sequential successor of a fetch PC (wraps mod 2^32)
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/if_fetch_inst_assembler.sv
// Collects four returned bytes into a little-endian 32-bit instruction word.
// i_clear wipes the partial word and count; i_drop discards the byte arriving
// this cycle without counting it.
module if_fetch_inst_assembler
    import if_fetch_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_drop,
    input  logic               i_valid,
    input  logic [BYTE_W-1:0]  i_byte,
    output logic [CNT_W-1:0]   o_cnt,
    output logic [INST_W-1:0]  o_inst
);

    logic [CNT_W-1:0]  r_cnt;
    logic [INST_W-1:0] r_inst;
    logic              w_accept;

    // A byte lands only when it is real, not flagged stale, and a slot is free
    assign w_accept = i_valid && !i_drop && !i_clear && (r_cnt < CNT_FULL);

    // Byte counter and assembly register; byte k goes to bits [8k+7:8k]
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_inst <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_inst <= '0;
        end else if (w_accept) begin
            r_inst[{r_cnt[1:0], 3'b000} +: BYTE_W] <= i_byte;
            r_cnt                                  <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_inst = r_inst;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch over a shared 8-bit memory port. Issues four byte reads
// per instruction, assembles the reply, and hands the word to IF/ID as a
// one-cycle pulse. Honours PC/IF stall bits and EX branch redirects.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [STALL_W-1:0]  stall_in,
    input  logic                branch_in,
    input  logic [ADDR_W-1:0]   branchTarget_in,
    input  logic                memGrant_in,
    input  logic [BYTE_W-1:0]   memData_in,
    output logic                memReq_out,
    output logic [ADDR_W-1:0]   memAddr_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [INST_W-1:0]   inst_out,
    output logic                instValid_out,
    output logic                ifStall_out
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [CNT_W-1:0]  w_issue_cnt_nxt;
    logic              r_adv_pend;      // handed off, PC advance waiting on stall bit 0
    logic              w_adv_pend_nxt;
    logic              r_run;           // low for the first cycle after reset release
    logic              r_rsp_pend;      // a granted request returns data this cycle
    logic              r_drop;          // that returning byte belongs to a redirected fetch
    logic              r_inst_valid;
    logic [ADDR_W-1:0] r_pc_out;
    logic [INST_W-1:0] r_inst_out;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_pc_hold;
    logic              w_if_hold;
    logic              w_mem_req;
    logic              w_issue;
    logic              w_complete;
    logic              w_handoff;
    logic              w_clear;
    logic [CNT_W-1:0]  w_recv_cnt;
    logic [INST_W-1:0] w_inst;
    logic              w_unused_stall;

    assign w_pc_hold = stall_in[STALL_PC];
    assign w_if_hold = stall_in[STALL_IF];

    // Remaining stall bits belong to later stages
    assign w_unused_stall = &{1'b0, stall_in[STALL_W-1:2]};

    assign w_mem_req = r_run && (r_state == StFetch) && !r_adv_pend &&
                       (r_issue_cnt < CNT_FULL);
    assign w_issue   = w_mem_req && memGrant_in;

    assign w_complete = (r_state == StFetch) && (w_recv_cnt == CNT_FULL);

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    if_fetch_inst_assembler u_inst_assembler (
        .i_clk   (clk_in),
        .i_rst_n (rst_in),
        .i_clear (w_clear),
        .i_drop  (r_drop),
        .i_valid (r_rsp_pend),
        .i_byte  (memData_in),
        .o_cnt   (w_recv_cnt),
        .o_inst  (w_inst)
    );

    // ------------------------------------------------------------------
    // Next-state logic: branch beats everything, then hand-off / hold
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_issue_cnt_nxt = r_issue_cnt + CNT_W'(w_issue);
        w_adv_pend_nxt  = r_adv_pend;
        w_clear         = 1'b0;
        w_handoff       = 1'b0;

        if (branch_in) begin
            // Redirect: abandon partial word and any held instruction
            w_state_nxt     = StFetch;
            w_fetch_pc_nxt  = branchTarget_in;
            w_issue_cnt_nxt = '0;
            w_adv_pend_nxt  = 1'b0;
            w_clear         = 1'b1;
        end else begin
            case (r_state)
                StFetch: begin
                    if (w_complete) begin
                        if (w_if_hold) begin
                            w_state_nxt = StHold;
                        end else begin
                            w_handoff = 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (!w_if_hold) begin
                        w_handoff   = 1'b1;
                        w_state_nxt = StFetch;
                    end
                end
                default: begin
                    w_state_nxt = StFetch;
                end
            endcase

            if (w_handoff) begin
                w_clear         = 1'b1;
                w_issue_cnt_nxt = '0;
                if (w_pc_hold) begin
                    w_adv_pend_nxt = 1'b1;
                end else begin
                    w_fetch_pc_nxt = next_pc(r_fetch_pc);
                end
            end else if (r_adv_pend && !w_pc_hold) begin
                // Deferred advance; no fetch runs while it is pending
                w_fetch_pc_nxt = next_pc(r_fetch_pc);
                w_adv_pend_nxt = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state registers
    // ------------------------------------------------------------------
    // FSM state, fetch PC, issue counter and deferred-advance flag
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= StFetch;
            r_fetch_pc  <= '0;
            r_issue_cnt <= '0;
            r_adv_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
            r_adv_pend  <= w_adv_pend_nxt;
        end
    end

    // Memory response tracking; a grant in the branch cycle is marked stale
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_run      <= 1'b0;
            r_rsp_pend <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_rsp_pend <= w_issue;
            r_drop     <= w_issue && branch_in;
        end
    end

    // Hand-off registers toward IF/ID
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_inst_valid <= 1'b0;
            r_pc_out     <= '0;
            r_inst_out   <= '0;
        end else begin
            r_inst_valid <= w_handoff;
            if (w_handoff) begin
                r_pc_out   <= r_fetch_pc;
                r_inst_out <= w_inst;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign memReq_out    = w_mem_req;
    assign memAddr_out   = w_mem_req ? (r_fetch_pc + ADDR_W'(r_issue_cnt)) : '0;
    assign pc_out        = r_pc_out;
    assign inst_out      = r_inst_out;
    // A redirect squashes whatever IF/ID would accept this cycle
    assign instValid_out = r_inst_valid && !branch_in;
    assign ifStall_out   = r_run && (r_state == StFetch) && (w_recv_cnt < CNT_FULL);

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: expected addresses and instructions are queued
// when a scenario is set up and consumed as the DUT issues grants / hand-offs.
module tb_if_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [5:0]  stall_in;
    logic        branch_in;
    logic [31:0] branchTarget_in;
    logic        memGrant_in;
    logic [7:0]  memData_in;
    logic        memReq_out;
    logic [31:0] memAddr_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        instValid_out;
    logic        ifStall_out;

    always #5 clk_in = ~clk_in;

    if_fetch u_dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .stall_in        (stall_in),
        .branch_in       (branch_in),
        .branchTarget_in (branchTarget_in),
        .memGrant_in     (memGrant_in),
        .memData_in      (memData_in),
        .memReq_out      (memReq_out),
        .memAddr_out     (memAddr_out),
        .pc_out          (pc_out),
        .inst_out        (inst_out),
        .instValid_out   (instValid_out),
        .ifStall_out     (ifStall_out)
    );

    int          n_total   = 0;
    int          n_bad     = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_ins[$];
    int          a_rd      = 0;
    int          i_rd      = 0;
    int          stall_cnt = 0;
    int          stall_base;
    logic        pend_v    = 1'b0;
    logic [31:0] pend_a    = '0;
    logic        prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Memory contents: word 0 is 0x00000013, elsewhere an address-derived pattern
    function automatic logic [7:0] byte_at(input logic [31:0] a);
        if (a == 32'd0) return 8'h13;
        if (a < 32'd4) return 8'h00;
        return (a[7:0] + 8'h11) ^ a[15:8];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {byte_at(pc + 32'd3), byte_at(pc + 32'd2), byte_at(pc + 32'd1), byte_at(pc)};
    endfunction

    task automatic push_addr(input logic [31:0] a);
        exp_addr.push_back(a);
    endtask

    task automatic push_fetch(input logic [31:0] pc);
        for (int k = 0; k < 4; k++) push_addr(pc + 32'(k));
        exp_pc.push_back(pc);
        exp_ins.push_back(word_at(pc));
    endtask

    // Mid-cycle: answer last cycle's grant, score issued addresses and hand-offs
    task automatic monitor();
        memData_in = pend_v ? byte_at(pend_a) : 8'h00;
        pend_v     = memReq_out && memGrant_in;
        pend_a     = memAddr_out;
        if (pend_v) begin
            chk("addr_expected", {31'b0, a_rd < exp_addr.size()}, 32'd1);
            if (a_rd < exp_addr.size()) begin
                chk("addr", memAddr_out, exp_addr[a_rd]);
                a_rd++;
            end
        end
        if (instValid_out) begin
            chk("valid_gap", {31'b0, prev_valid}, 32'd0);
            chk("inst_expected", {31'b0, i_rd < exp_pc.size()}, 32'd1);
            if (i_rd < exp_pc.size()) begin
                chk("pc_out", pc_out, exp_pc[i_rd]);
                chk("inst_out", inst_out, exp_ins[i_rd]);
                i_rd++;
            end
        end
        prev_valid = instValid_out;
        if (ifStall_out && (i_rd < exp_pc.size())) stall_cnt++;
    endtask

    task automatic step();
        @(negedge clk_in);
        monitor();
        @(posedge clk_in);
        #1;
    endtask

    // Run until queued addresses (and optionally instructions) are consumed;
    // grant drops as soon as no more addresses are expected.
    task automatic drain(input bit need_inst, input string tag, input int budget);
        int n = 0;
        while (n < budget &&
               (a_rd != exp_addr.size() || (need_inst && i_rd != exp_pc.size()))) begin
            step();
            n++;
            if (a_rd == exp_addr.size()) memGrant_in = 1'b0;
        end
        chk(tag, {31'b0, n < budget}, 32'd1);
    endtask

    initial begin
        rst_in          = 1'b1;
        stall_in        = '0;
        branch_in       = 1'b0;
        branchTarget_in = '0;
        memGrant_in     = 1'b0;
        memData_in      = '0;
        #2 rst_in = 1'b0;
        #1;
        chk("rst_req",   {31'b0, memReq_out},    32'd0);
        chk("rst_addr",  memAddr_out,            32'd0);
        chk("rst_pc",    pc_out,                 32'd0);
        chk("rst_inst",  inst_out,               32'd0);
        chk("rst_valid", {31'b0, instValid_out}, 32'd0);
        chk("rst_stall", {31'b0, ifStall_out},   32'd0);
        step();
        step();

        // Basic fetch of word 0 with a permanent grant
        stall_base = stall_cnt;
        push_fetch(32'd0);
        memGrant_in = 1'b1;
        rst_in      = 1'b1;
        drain(1'b1, "s1_done", 40);
        chk("s1_stall_cycles", 32'(stall_cnt - stall_base), 32'd5);
        chk("s1_next_req",  {31'b0, memReq_out}, 32'd1);
        chk("s1_next_addr", memAddr_out,         32'd4);

        // Grant gap of two cycles after the second byte
        stall_base = stall_cnt;
        push_fetch(32'd4);
        memGrant_in = 1'b1;
        step();
        step();
        memGrant_in = 1'b0;
        step();
        step();
        memGrant_in = 1'b1;
        drain(1'b1, "s2_done", 40);
        chk("s2_stall_cycles", 32'(stall_cnt - stall_base), 32'd7);

        // Completion under IF stall: park in HOLD, release later
        push_fetch(32'd8);
        stall_in    = 6'b011111;
        memGrant_in = 1'b1;
        drain(1'b0, "s3_issue", 40);
        step();
        step();
        step();
        chk("s3_hold_req",   {31'b0, memReq_out},    32'd0);
        chk("s3_hold_stall", {31'b0, ifStall_out},   32'd0);
        chk("s3_hold_valid", {31'b0, instValid_out}, 32'd0);
        chk("s3_hold_pc",    pc_out,                 32'd4);
        stall_in = '0;
        drain(1'b1, "s3_done", 40);
        chk("s3_valid_once", {31'b0, instValid_out}, 32'd0);
        chk("s3_next_req",   {31'b0, memReq_out},    32'd1);
        chk("s3_next_addr",  memAddr_out,            32'd12);

        // PC hold only: hand-off happens, advance waits for the bit to clear
        push_fetch(32'd12);
        stall_in    = 6'b000001;
        memGrant_in = 1'b1;
        drain(1'b1, "s3b_done", 40);
        chk("s3b_defer_req0", {31'b0, memReq_out}, 32'd0);
        step();
        step();
        chk("s3b_defer_req1", {31'b0, memReq_out}, 32'd0);
        stall_in = '0;
        step();
        chk("s3b_resume_req",  {31'b0, memReq_out}, 32'd1);
        chk("s3b_resume_addr", memAddr_out,         32'd16);

        // Branch after two grants; the grant in the branch cycle is stale
        push_addr(32'd16);
        push_addr(32'd17);
        push_addr(32'd18);
        push_fetch(32'h100);
        memGrant_in = 1'b1;
        step();
        step();
        branch_in       = 1'b1;
        branchTarget_in = 32'h100;
        step();
        branch_in = 1'b0;
        drain(1'b1, "s4_done", 40);

        // Branch while holding a finished word: the held word must vanish
        push_addr(32'h104);
        push_addr(32'h105);
        push_addr(32'h106);
        push_addr(32'h107);
        stall_in    = 6'b000010;
        memGrant_in = 1'b1;
        drain(1'b0, "s5_issue", 40);
        step();
        step();
        step();
        chk("s5_hold_req",   {31'b0, memReq_out},  32'd0);
        chk("s5_hold_stall", {31'b0, ifStall_out}, 32'd0);
        push_fetch(32'h200);
        branch_in       = 1'b1;
        branchTarget_in = 32'h200;
        memGrant_in     = 1'b1;
        step();
        branch_in = 1'b0;
        stall_in  = '0;
        drain(1'b1, "s5_done", 40);

        // Reset with two bytes received
        push_addr(32'h204);
        push_addr(32'h205);
        memGrant_in = 1'b1;
        drain(1'b0, "s6_issue", 40);
        step();
        rst_in = 1'b0;
        #1;
        chk("s6_rst_req",   {31'b0, memReq_out},    32'd0);
        chk("s6_rst_addr",  memAddr_out,            32'd0);
        chk("s6_rst_pc",    pc_out,                 32'd0);
        chk("s6_rst_inst",  inst_out,               32'd0);
        chk("s6_rst_valid", {31'b0, instValid_out}, 32'd0);
        chk("s6_rst_stall", {31'b0, ifStall_out},   32'd0);
        step();
        step();
        rst_in = 1'b1;
        #1;
        chk("s6_first_wait", {31'b0, memReq_out}, 32'd0);
        step();
        chk("s6_first_req",  {31'b0, memReq_out}, 32'd1);
        chk("s6_first_addr", memAddr_out,         32'd0);
        push_fetch(32'd0);
        memGrant_in = 1'b1;
        drain(1'b1, "s6_done", 40);

        chk("addr_left", 32'(exp_addr.size() - a_rd), 32'd0);
        chk("inst_left", 32'(exp_pc.size() - i_rd),   32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
